// File: rtl/alu_seq_if.sv
// Requester-side bundle for alu_seq: start/ready/done handshake, operands and result.
interface alu_seq_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned WORDS = 4
);
    localparam int unsigned N = WIDTH * WORDS;

    logic           start;
    logic [2:0]     op;
    logic [N-1:0]   opa;
    logic [N-1:0]   opb;
    logic           ready;
    logic           done;
    logic           err;
    logic [N-1:0]   result;
    logic           cout;

    modport master (
        output start, op, opa, opb,
        input  ready, done, err, result, cout
    );

    modport slave (
        input  start, op, opa, opb,
        output ready, done, err, result, cout
    );
endinterface

// File: rtl/alu_seq.sv
// Multi-precision sequencer: runs a WIDTH-bit combinational alu slice by slice,
// LSB slice first, chaining the carry through a register.
module alu_seq #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned WORDS = 4
) (
    input  logic             clk,
    input  logic             reset,
    alu_seq_if.slave         req,
    output logic             x,
    output logic             y,
    output logic             z,
    output logic             w,
    output logic             ci,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] g
);
    localparam int unsigned N  = WIDTH * WORDS;
    localparam int unsigned KW = $clog2(WORDS);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;

    logic [1:0]       state, state_n;
    logic [N-1:0]     opa_l, opa_n;
    logic [N-1:0]     opb_l, opb_n;
    logic [2:0]       op_l, op_n;
    logic [KW-1:0]    k, k_n;
    logic             carry, carry_n;
    logic [N-1:0]     result_q, result_n;
    logic             cout_q, cout_n;
    logic             err_q, err_n;
    logic             ready_q, ready_n;
    logic             done_q, done_n;
    logic [3:0]       sel_q, sel_n;
    logic             ci_q, ci_n;
    logic [WIDTH-1:0] a_q, a_n;
    logic [WIDTH-1:0] b_q, b_n;

    // Only the slice carry-out feeds the chain; lower carry bits are intentionally dropped.
    logic [WIDTH-2:0] c_unused;
    assign c_unused = c[WIDTH-2:0];

    function automatic logic [3:0] sel_of(input logic [2:0] o);
        case (o)
            OP_ADD:  sel_of = 4'b0100;
            OP_SUB:  sel_of = 4'b1100;
            OP_AND:  sel_of = 4'b0010;
            OP_OR:   sel_of = 4'b0011;
            OP_XOR:  sel_of = 4'b0000;
            default: sel_of = 4'b0000;
        endcase
    endfunction

    function automatic logic is_arith(input logic [2:0] o);
        is_arith = (o == OP_ADD) || (o == OP_SUB);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            opa_l    <= '0;
            opb_l    <= '0;
            op_l     <= '0;
            k        <= '0;
            carry    <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            err_q    <= 1'b0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            sel_q    <= 4'b0000;
            ci_q     <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
        end else begin
            state    <= state_n;
            opa_l    <= opa_n;
            opb_l    <= opb_n;
            op_l     <= op_n;
            k        <= k_n;
            carry    <= carry_n;
            result_q <= result_n;
            cout_q   <= cout_n;
            err_q    <= err_n;
            ready_q  <= ready_n;
            done_q   <= done_n;
            sel_q    <= sel_n;
            ci_q     <= ci_n;
            a_q      <= a_n;
            b_q      <= b_n;
        end
    end

    // Next state plus the registered alu drive for the slice presented next cycle.
    always_comb begin
        state_n  = state;
        opa_n    = opa_l;
        opb_n    = opb_l;
        op_n     = op_l;
        k_n      = k;
        carry_n  = carry;
        result_n = result_q;
        cout_n   = cout_q;
        err_n    = err_q;
        ready_n  = 1'b0;
        done_n   = 1'b0;
        sel_n    = 4'b0000;
        ci_n     = 1'b0;
        a_n      = '0;
        b_n      = '0;

        case (state)
            IDLE: begin
                if (req.start) begin
                    opa_n   = req.opa;
                    opb_n   = req.opb;
                    op_n    = req.op;
                    err_n   = 1'b0;
                    k_n     = '0;
                    carry_n = (req.op == OP_SUB);
                    if (req.op <= OP_XOR) begin
                        state_n = RUN;
                    end else begin
                        state_n  = DONE;
                        err_n    = 1'b1;
                        result_n = '0;
                        cout_n   = 1'b0;
                    end
                end
            end
            RUN: begin
                result_n[int'(k)*WIDTH +: WIDTH] = g;
                carry_n = c[WIDTH-1];
                if (k == KW'(WORDS - 1)) begin
                    state_n = DONE;
                    k_n     = '0;
                    cout_n  = is_arith(op_l) ? c[WIDTH-1] : 1'b0;
                end else begin
                    k_n = k + KW'(1);
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        ready_n = (state_n == IDLE);
        done_n  = (state_n == DONE);
        if (state_n == RUN) begin
            a_n   = opa_n[int'(k_n)*WIDTH +: WIDTH];
            b_n   = opb_n[int'(k_n)*WIDTH +: WIDTH];
            sel_n = sel_of(op_n);
            ci_n  = is_arith(op_n) ? carry_n : 1'b0;
        end
    end

    assign req.ready  = ready_q;
    assign req.done   = done_q;
    assign req.err    = err_q;
    assign req.result = result_q;
    assign req.cout   = cout_q;

    assign x  = sel_q[3];
    assign y  = sel_q[2];
    assign z  = sel_q[1];
    assign w  = sel_q[0];
    assign ci = ci_q;
    assign a  = a_q;
    assign b  = b_q;
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: behavioural alu slice, transaction model, directed vectors.
module tb_alu_seq;
    localparam int unsigned W = 4;
    localparam int unsigned WORDS = 4;
    localparam int unsigned N = W * WORDS;

    logic clk = 1'b0;
    logic reset;
    logic x, y, z, w, ci;
    logic [W-1:0] a, b, c, g;

    int total = 0;
    int bad = 0;

    alu_seq_if #(.WIDTH(W), .WORDS(WORDS)) bus ();

    alu_seq #(.WIDTH(W), .WORDS(WORDS)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (bus),
        .x     (x),
        .y     (y),
        .z     (z),
        .w     (w),
        .ci    (ci),
        .a     (a),
        .b     (b),
        .c     (c),
        .g     (g)
    );

    always #5 clk = ~clk;

    // Behavioural alu slice: ripple add of a + (x ? ~b : b) + ci, or a plain logic op.
    logic [W-1:0] alu_bb;
    logic         alu_cy;
    always_comb begin
        g = '0;
        c = '0;
        alu_cy = ci;
        alu_bb = x ? ~b : b;
        case ({x, y, z, w})
            4'b0100, 4'b1100: begin
                for (int i = 0; i < W; i++) begin
                    g[i]   = a[i] ^ alu_bb[i] ^ alu_cy;
                    alu_cy = (a[i] & alu_bb[i]) | (alu_cy & (a[i] ^ alu_bb[i]));
                    c[i]   = alu_cy;
                end
            end
            4'b0010: g = a & b;
            4'b0011: g = a | b;
            default: g = a ^ b;
        endcase
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: answer computed with whole-word arithmetic at accept time.
    logic          check_en = 1'b0;
    logic          m_ready = 1'b1, m_done = 1'b0, m_err = 1'b0, m_cout = 1'b0;
    logic [N-1:0]  m_res = '0, m_full = '0, m_a = '0, m_b = '0;
    logic          m_fcout = 1'b0;
    logic [2:0]    m_op = '0;
    int            m_left = 0, m_slice = 0;

    always @(posedge clk) begin
        logic [N:0] s;
        if (reset) begin
            m_ready = 1'b1; m_done = 1'b0; m_err = 1'b0; m_res = '0; m_cout = 1'b0;
            m_left = 0; check_en = 1'b1;
        end else if (m_done) begin
            m_done = 1'b0; m_ready = 1'b1;
        end else if (m_left > 0) begin
            m_left--; m_slice++;
            if (m_left == 0) begin
                m_done = 1'b1; m_res = m_full; m_cout = m_fcout;
            end
        end else if (m_ready && bus.start) begin
            m_op = bus.op; m_a = bus.opa; m_b = bus.opb;
            m_slice = 0; m_ready = 1'b0; m_err = 1'b0;
            case (bus.op)
                3'd0: begin s = {1'b0, m_a} + {1'b0, m_b}; m_full = s[N-1:0]; m_fcout = s[N]; end
                3'd1: begin s = {1'b0, m_a} + {1'b0, ~m_b} + 1; m_full = s[N-1:0]; m_fcout = s[N]; end
                3'd2: begin m_full = m_a & m_b; m_fcout = 1'b0; end
                3'd3: begin m_full = m_a | m_b; m_fcout = 1'b0; end
                3'd4: begin m_full = m_a ^ m_b; m_fcout = 1'b0; end
                default: begin m_full = '0; m_fcout = 1'b0; end
            endcase
            if (bus.op > 3'd4) begin
                m_done = 1'b1; m_err = 1'b1; m_res = '0; m_cout = 1'b0;
            end else begin
                m_left = WORDS;
            end
        end
    end

    function automatic logic carry_into(input logic [2:0] o, input logic [N-1:0] va,
                                        input logic [N-1:0] vb, input int j);
        logic [63:0] lm, s;
        lm = (64'd1 << (j * W)) - 64'd1;
        if (o == 3'd0) s = (64'(va) & lm) + (64'(vb) & lm);
        else           s = (64'(va) & lm) + (64'(~vb) & lm) + 64'd1;
        return s[j * W];
    endfunction

    // Per-cycle compare of every meaningful output against the model.
    always @(negedge clk) begin
        logic [W-1:0] ea, eb;
        logic [3:0]   esel;
        logic         eci;
        if (check_en) begin
            chk("ready", 64'(bus.ready), 64'(m_ready));
            chk("done", 64'(bus.done), 64'(m_done));
            if (m_ready || m_done) begin
                chk("result", 64'(bus.result), 64'(m_res));
                chk("cout", 64'(bus.cout), 64'(m_cout));
                chk("err", 64'(bus.err), 64'(m_err));
            end
            ea = '0; eb = '0; esel = 4'b0000; eci = 1'b0;
            if (m_left > 0) begin
                ea = W'(m_a >> (m_slice * W));
                eb = W'(m_b >> (m_slice * W));
                case (m_op)
                    3'd0: esel = 4'b0100;
                    3'd1: esel = 4'b1100;
                    3'd2: esel = 4'b0010;
                    3'd3: esel = 4'b0011;
                    default: esel = 4'b0000;
                endcase
                eci = (m_op <= 3'd1) ? carry_into(m_op, m_a, m_b, m_slice) : 1'b0;
            end
            chk("alu_a", 64'(a), 64'(ea));
            chk("alu_b", 64'(b), 64'(eb));
            chk("alu_sel", 64'({x, y, z, w}), 64'(esel));
            chk("alu_ci", 64'(ci), 64'(eci));
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!bus.ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", 64'(bus.ready), 64'd1);
    endtask

    // One directed operation with hand-computed expectations; operands scrambled mid-run.
    task automatic run_op(input string name, input logic [2:0] o, input logic [N-1:0] va,
                          input logic [N-1:0] vb, input logic [N-1:0] er, input logic ec,
                          input logic eerr, input logic [WORDS-1:0] eci, input logic [3:0] esel);
        int n;
        logic [WORDS-1:0] ci_seq;
        logic [3:0] sel0;
        wait_ready();
        bus.start = 1'b1; bus.op = o; bus.opa = va; bus.opb = vb;
        @(negedge clk);
        bus.start = 1'b0;
        ci_seq = '0;
        sel0 = {x, y, z, w};
        n = 0;
        while (!bus.done && n < 20) begin
            if (n < WORDS) ci_seq[n] = ci;
            bus.opa = N'($urandom); bus.opb = N'($urandom); bus.op = 3'($urandom);
            @(negedge clk);
            n++;
        end
        chk({name, "_latency"}, 64'(n), eerr ? 64'd0 : 64'(WORDS));
        chk({name, "_result"}, 64'(bus.result), 64'(er));
        chk({name, "_cout"}, 64'(bus.cout), 64'(ec));
        chk({name, "_err"}, 64'(bus.err), 64'(eerr));
        chk({name, "_ci_seq"}, 64'(ci_seq), 64'(eci));
        chk({name, "_sel"}, 64'(sel0), 64'(esel));
        @(negedge clk);
        chk({name, "_ready_back"}, 64'(bus.ready), 64'd1);
        chk({name, "_held"}, 64'(bus.result), 64'(er));
    endtask

    initial begin
        int dones, first_done, last_done;
        reset = 1'b1;
        bus.start = 1'b0; bus.op = '0; bus.opa = '0; bus.opb = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", 64'(bus.ready), 64'd1);
        chk("rst_result", 64'(bus.result), 64'd0);
        chk("rst_alu", 64'({x, y, z, w, ci, a, b}), 64'd0);

        run_op("add_wrap", 3'b000, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 4'b1110, 4'b0100);
        run_op("sub_borrow", 3'b001, 16'h1234, 16'h1235, 16'hFFFF, 1'b0, 1'b0, 4'b0001, 4'b1100);
        run_op("sub_pos", 3'b001, 16'h1235, 16'h1234, 16'h0001, 1'b1, 1'b0, 4'b1111, 4'b1100);
        run_op("and", 3'b010, 16'hC3A5, 16'h0FF0, 16'h03A0, 1'b0, 1'b0, 4'b0000, 4'b0010);
        run_op("or", 3'b011, 16'hC3A5, 16'h0FF0, 16'hCFF5, 1'b0, 1'b0, 4'b0000, 4'b0011);
        run_op("xor", 3'b100, 16'hC3A5, 16'h0FF0, 16'hCC55, 1'b0, 1'b0, 4'b0000, 4'b0000);
        run_op("illegal7", 3'b111, 16'hABCD, 16'h1111, 16'h0000, 1'b0, 1'b1, 4'b0000, 4'b0000);
        run_op("illegal5", 3'b101, 16'h0001, 16'h0001, 16'h0000, 1'b0, 1'b1, 4'b0000, 4'b0000);

        // start held high: later requests are only taken once the sequencer is idle again.
        wait_ready();
        bus.start = 1'b1; bus.op = 3'b000; bus.opa = 16'h0001; bus.opb = 16'h0002;
        dones = 0; first_done = -1; last_done = -1;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            if (bus.done) begin
                dones++;
                if (first_done < 0) first_done = i;
                last_done = i;
            end
        end
        bus.start = 1'b0;
        chk("b2b_dones", 64'(dones), 64'd3);
        chk("b2b_first", 64'(first_done), 64'd4);
        chk("b2b_last", 64'(last_done), 64'd16);

        // Reset applied on edge 2 of an ADD.
        wait_ready();
        bus.start = 1'b1; bus.op = 3'b000; bus.opa = 16'hFFFF; bus.opb = 16'h0001;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bus.start = 1'b0;
        chk("midrst_ready", 64'(bus.ready), 64'd1);
        chk("midrst_done", 64'(bus.done), 64'd0);
        chk("midrst_result", 64'(bus.result), 64'd0);
        dones = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        chk("midrst_no_done", 64'(dones), 64'd0);
        run_op("add_after_rst", 3'b000, 16'h0F0F, 16'h00F1, 16'h1000, 1'b0, 1'b0, 4'b1110, 4'b0100);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
